// File: rtl/sdram_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_lane_buffer
//  Brief    : Packs pixels into one lane of the SDRAM word, drives DQM, and
//             rotates write/read lanes per frame (ping-pong or triple+ buffer).
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_lane_buffer #(
    parameter int  DQ_W   = 32,
    parameter int  LANE_W = 16,
    localparam int LANES  = DQ_W / LANE_W,
    localparam int IDX_W  = $clog2(LANES),
    localparam int BM_W   = DQ_W / 8,
    localparam int BPL    = LANE_W / 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              wr_frame_end,
    input  logic              rd_frame_end,
    input  logic [LANE_W-1:0] wr_data_in,
    output logic [DQ_W-1:0]   wr_dq_out,
    input  logic [DQ_W-1:0]   rd_dq_in,
    input  logic              rd_dq_valid,
    output logic [LANE_W-1:0] rd_data_out,
    output logic              rd_data_valid,
    output logic [BM_W-1:0]   sdram_dqm,
    output logic [IDX_W-1:0]  wr_lane,
    output logic [IDX_W-1:0]  rd_lane,
    output logic              frame_ready,
    output logic              rd_repeat
);

    localparam logic [IDX_W-1:0] c_LAST_LANE = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] c_ONE       = IDX_W'(1);

    logic [BM_W-1:0]   r_dqm;
    logic [IDX_W-1:0]  r_wr_lane;
    logic [IDX_W-1:0]  r_rd_lane;
    logic [IDX_W-1:0]  r_last_done;
    logic              r_fresh;
    logic              r_frame_ready;
    logic              r_rd_repeat;
    logic [LANE_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic [BM_W-1:0]   w_wr_mask;
    logic [LANE_W-1:0] w_rd_sel;
    logic [IDX_W-1:0]  w_step1;
    logic [IDX_W-1:0]  w_step2;
    logic [IDX_W-1:0]  w_rd_next;
    logic [IDX_W-1:0]  w_wr_next;
    logic [IDX_W-1:0]  w_last_next;
    logic              w_fresh_next;
    logic              w_ready_next;
    logic              w_repeat_next;

    // Per-lane data placement and byte-mask generation
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_dq_out[gi*LANE_W +: LANE_W] =
                (r_wr_lane == IDX_W'(gi)) ? wr_data_in : '0;
            assign w_wr_mask[gi*BPL +: BPL] =
                (r_wr_lane == IDX_W'(gi)) ? '0 : '1;
        end
    endgenerate

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_rd_lane == IDX_W'(i)) begin
                w_rd_sel = rd_dq_in[i*LANE_W +: LANE_W];
            end
        end
    end

    // Wrap-around increments keep indices in range for non-power-of-2 LANES
    assign w_step1 = (r_wr_lane == c_LAST_LANE) ? '0 : r_wr_lane + c_ONE;
    assign w_step2 = (w_step1   == c_LAST_LANE) ? '0 : w_step1   + c_ONE;

    always_comb begin
        w_rd_next     = r_rd_lane;
        w_wr_next     = r_wr_lane;
        w_last_next   = r_last_done;
        w_fresh_next  = r_fresh;
        w_ready_next  = r_frame_ready;
        w_repeat_next = 1'b0;

        if (rd_frame_end) begin
            if (r_fresh) begin
                w_rd_next    = r_last_done;
                w_fresh_next = 1'b0;
                w_ready_next = 1'b1;
            end else begin
                w_repeat_next = 1'b1;
            end
        end

        // Write side sees the read lane already updated this cycle
        if (wr_frame_end) begin
            w_last_next  = r_wr_lane;
            w_fresh_next = 1'b1;
            if (LANES == 2) begin
                w_wr_next = ~r_wr_lane;
            end else if (w_step1 != w_rd_next) begin
                w_wr_next = w_step1;
            end else begin
                w_wr_next = w_step2;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_dqm         <= '0;
            r_wr_lane     <= '0;
            r_rd_lane     <= '0;
            r_last_done   <= '0;
            r_fresh       <= 1'b0;
            r_frame_ready <= 1'b0;
            r_rd_repeat   <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
        end else begin
            if (wr_en) begin
                r_dqm <= w_wr_mask;
            end else if (rd_en) begin
                r_dqm <= '0;
            end

            if (rd_dq_valid) begin
                r_rd_data <= w_rd_sel;
            end
            r_rd_valid    <= rd_dq_valid;

            r_wr_lane     <= w_wr_next;
            r_rd_lane     <= w_rd_next;
            r_last_done   <= w_last_next;
            r_fresh       <= w_fresh_next;
            r_frame_ready <= w_ready_next;
            r_rd_repeat   <= w_repeat_next;
        end
    end

    assign sdram_dqm     = r_dqm;
    assign wr_lane       = r_wr_lane;
    assign rd_lane       = r_rd_lane;
    assign frame_ready   = r_frame_ready;
    assign rd_repeat     = r_rd_repeat;
    assign rd_data_out   = r_rd_data;
    assign rd_data_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sdram_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_lane_buffer
//  Brief    : Vector table on a 2-lane instance, hand sequences on a 3-lane one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_lane_buffer;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 2-lane instance (DQ_W=32) ----------------
    logic        a_rst_n, a_we, a_re, a_wfe, a_rfe, a_rv;
    logic [15:0] a_wd, a_rdata;
    logic [31:0] a_rdq, a_dq;
    logic        a_rvalid, a_ready, a_rep;
    logic [3:0]  a_dqm;
    logic [0:0]  a_wl, a_rl;

    sdram_lane_buffer #(.DQ_W(32), .LANE_W(16)) u_dut2 (
        .sys_clk       (sys_clk),
        .sys_rst_n     (a_rst_n),
        .wr_en         (a_we),
        .rd_en         (a_re),
        .wr_frame_end  (a_wfe),
        .rd_frame_end  (a_rfe),
        .wr_data_in    (a_wd),
        .wr_dq_out     (a_dq),
        .rd_dq_in      (a_rdq),
        .rd_dq_valid   (a_rv),
        .rd_data_out   (a_rdata),
        .rd_data_valid (a_rvalid),
        .sdram_dqm     (a_dqm),
        .wr_lane       (a_wl),
        .rd_lane       (a_rl),
        .frame_ready   (a_ready),
        .rd_repeat     (a_rep)
    );

    // ---------------- 3-lane instance (DQ_W=48) ----------------
    logic        b_rst_n, b_we, b_re, b_wfe, b_rfe, b_rv;
    logic [15:0] b_wd, b_rdata;
    logic [47:0] b_rdq, b_dq;
    logic        b_rvalid, b_ready, b_rep;
    logic [5:0]  b_dqm;
    logic [1:0]  b_wl, b_rl;

    sdram_lane_buffer #(.DQ_W(48), .LANE_W(16)) u_dut3 (
        .sys_clk       (sys_clk),
        .sys_rst_n     (b_rst_n),
        .wr_en         (b_we),
        .rd_en         (b_re),
        .wr_frame_end  (b_wfe),
        .rd_frame_end  (b_rfe),
        .wr_data_in    (b_wd),
        .wr_dq_out     (b_dq),
        .rd_dq_in      (b_rdq),
        .rd_dq_valid   (b_rv),
        .rd_data_out   (b_rdata),
        .rd_data_valid (b_rvalid),
        .sdram_dqm     (b_dqm),
        .wr_lane       (b_wl),
        .rd_lane       (b_rl),
        .frame_ready   (b_ready),
        .rd_repeat     (b_rep)
    );

    typedef struct packed {
        logic        rst_n, we, re, wfe, rfe, rv;
        logic [15:0] wd;
        logic [31:0] rdq;
        logic [31:0] exp_dq;
        logic [3:0]  exp_dqm;
        logic        exp_wl, exp_rl, exp_ready, exp_rep, exp_rvalid;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic [3:0]  dqm;
        logic        wl, rl, ready, rep, rvalid;
        logic [15:0] rdata;
    } exp_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step3(input string tag, input logic we, input logic wfe, input logic rfe,
                         input logic rv, input logic [15:0] wd, input logic [47:0] rdq,
                         input logic [47:0] edq, input logic [1:0] ewl, input logic [1:0] erl,
                         input logic erep);
        @(negedge sys_clk);
        b_we = we; b_wfe = wfe; b_rfe = rfe; b_rv = rv; b_wd = wd; b_rdq = rdq;
        #1;
        check({tag, ".wr_dq_out"}, b_dq, edq);
        @(posedge sys_clk);
        #1;
        check({tag, ".wr_lane"}, b_wl, ewl);
        check({tag, ".rd_lane"}, b_rl, erl);
        check({tag, ".rd_repeat"}, b_rep, erep);
    endtask

    initial begin
        exp_t e;
        a_rst_n = 1'b0; a_we = 0; a_re = 0; a_wfe = 0; a_rfe = 0; a_rv = 0; a_wd = '0; a_rdq = '0;
        b_rst_n = 1'b0; b_we = 0; b_re = 0; b_wfe = 0; b_rfe = 0; b_rv = 0; b_wd = '0; b_rdq = '0;

        //            rst we re wfe rfe rv  wd        rdq            exp_dq         dqm     wl rl rdy rep rv  rdata
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'hABCD,32'h0,         32'h0000_ABCD,4'b1100,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b1100,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h1234,32'h0,         32'h1234_0000,4'b0011,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,32'hBEEF_0123, 32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b0,1'b1,16'h0123};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0123};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0123};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,32'hBEEF_0123, 32'h0000_0000,4'b0000,1'b0,1'b1,1'b1,1'b0,1'b1,16'hBEEF};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h5555,32'h0,         32'h0000_5555,4'b1100,1'b0,1'b1,1'b1,1'b0,1'b0,16'hBEEF};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b1100,1'b1,1'b1,1'b1,1'b0,1'b0,16'hBEEF};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'hAAAA,32'h0,         32'hAAAA_0000,4'b0011,1'b1,1'b1,1'b1,1'b0,1'b0,16'hBEEF};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,16'hFFFF,32'h1234_5678, 32'hFFFF_0000,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0,         32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,32'hCAFE_F00D, 32'h0000_0000,4'b0000,1'b1,1'b0,1'b1,1'b0,1'b1,16'hF00D};

        for (int k = 0; k < NV; k++) begin
            @(negedge sys_clk);
            a_rst_n = vecs[k].rst_n; a_we = vecs[k].we; a_re = vecs[k].re;
            a_wfe = vecs[k].wfe; a_rfe = vecs[k].rfe; a_rv = vecs[k].rv;
            a_wd = vecs[k].wd; a_rdq = vecs[k].rdq;
            #1;
            check($sformatf("v%0d.wr_dq_out", k), a_dq, vecs[k].exp_dq);
            exp_q.push_back('{vecs[k].exp_dqm, vecs[k].exp_wl, vecs[k].exp_rl, vecs[k].exp_ready,
                              vecs[k].exp_rep, vecs[k].exp_rvalid, vecs[k].exp_rdata});
            @(posedge sys_clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d.sdram_dqm", k), a_dqm, e.dqm);
            check($sformatf("v%0d.wr_lane", k), a_wl, e.wl);
            check($sformatf("v%0d.rd_lane", k), a_rl, e.rl);
            check($sformatf("v%0d.frame_ready", k), a_ready, e.ready);
            check($sformatf("v%0d.rd_repeat", k), a_rep, e.rep);
            check($sformatf("v%0d.rd_data_valid", k), a_rvalid, e.rvalid);
            check($sformatf("v%0d.rd_data_out", k), a_rdata, e.rdata);
        end

        // 3-lane rotation: reach wr=0, rd=1, last_done=2, fresh=1, then collide events
        @(negedge sys_clk);
        b_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check("l3.reset.dqm", b_dqm, 6'b000000);
        check("l3.reset.ready", b_ready, 1'b0);
        check("l3.reset.wr_lane", b_wl, 2'd0);
        b_rst_n = 1'b1;
        //       tag      we   wfe  rfe  rv   wd        rdq   exp_dq                wl    rl    rep
        step3("l3.s1", 1'b0,1'b1,1'b0,1'b0,16'h0000,48'h0,48'h0,                2'd1,2'd0,1'b0);
        step3("l3.s2", 1'b0,1'b1,1'b0,1'b0,16'h0000,48'h0,48'h0,                2'd2,2'd0,1'b0);
        step3("l3.s3", 1'b1,1'b0,1'b0,1'b0,16'hCAFE,48'h0,48'hCAFE_0000_0000,   2'd2,2'd0,1'b0);
        check("l3.s3.dqm", b_dqm, 6'b001111);
        step3("l3.s4", 1'b0,1'b0,1'b1,1'b0,16'h0000,48'h0,48'h0,                2'd2,2'd1,1'b0);
        check("l3.s4.ready", b_ready, 1'b1);
        step3("l3.s5", 1'b0,1'b1,1'b0,1'b0,16'h0000,48'h0,48'h0,                2'd0,2'd1,1'b0);
        step3("l3.both", 1'b0,1'b1,1'b1,1'b0,16'h0000,48'h0,48'h0,              2'd1,2'd2,1'b0);
        step3("l3.s7", 1'b0,1'b0,1'b1,1'b0,16'h0000,48'h0,48'h0,                2'd1,2'd0,1'b0);
        step3("l3.s8", 1'b0,1'b1,1'b0,1'b0,16'h0000,48'h0,48'h0,                2'd2,2'd0,1'b0);
        step3("l3.skip", 1'b0,1'b1,1'b0,1'b0,16'h0000,48'h0,48'h0,              2'd1,2'd0,1'b0);
        step3("l3.s10", 1'b0,1'b0,1'b1,1'b0,16'h0000,48'h0,48'h0,               2'd1,2'd2,1'b0);
        step3("l3.rd", 1'b0,1'b0,1'b0,1'b1,16'h0000,48'h1111_2222_3333,48'h0,   2'd1,2'd2,1'b0);
        check("l3.rd.data", b_rdata, 16'h1111);
        check("l3.rd.valid", b_rvalid, 1'b1);
        step3("l3.rep", 1'b0,1'b0,1'b1,1'b0,16'h0000,48'h0,48'h0,               2'd1,2'd2,1'b1);
        step3("l3.idle", 1'b0,1'b0,1'b0,1'b0,16'h0000,48'h0,48'h0,              2'd1,2'd2,1'b0);
        check("l3.idle.valid", b_rvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
